// File: rtl/rr_pkg.sv
// Shared register-file definitions used by fetch, register read and register write-back.
`default_nettype none
package rr_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;

  localparam logic [0:0] WB_IDLE  = 1'b0;
  localparam logic [0:0] WB_BURST = 1'b1;

  localparam logic [AW-1:0] REG_PC = 3'd7;

  localparam logic [DATA_W-1:0] REG_INIT [NREG] = '{
    16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0
  };
endpackage
`default_nettype wire

// File: rtl/register_writeback_if.sv
// Memory-stage write-back bus, read-stage ports and redirect outputs of the register file.
`default_nettype none
interface register_writeback_if;
  import rr_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic              wb_lm;
  logic [NREG-1:0]   wb_mask;
  logic [AW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [AW-1:0]     rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [AW-1:0]     rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              flush;
  logic              busy;

  modport slave (
    input  wb_valid, wb_lm, wb_mask, wb_rd, wb_data, rd_addr_a, rd_addr_b,
    output wb_ready, rd_data_a, rd_data_b, redirect_valid, redirect_pc, flush, busy
  );

  modport master (
    output wb_valid, wb_lm, wb_mask, wb_rd, wb_data, rd_addr_a, rd_addr_b,
    input  wb_ready, rd_data_a, rd_data_b, redirect_valid, redirect_pc, flush, busy
  );
endinterface
`default_nettype wire

// File: rtl/lm_priority_enc.sv
// Lowest-set-bit encoder for the load-multiple register mask.
`default_nettype none
module lm_priority_enc
  import rr_pkg::*;
(
  input  logic [NREG-1:0] mask_i,
  output logic [AW-1:0]   idx_o,
  output logic [NREG-1:0] clr_o,
  output logic            last_o
);

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = AW'(i);
    end
  end

  assign clr_o  = mask_i & (~mask_i + NREG'(1));
  assign last_o = (mask_i != '0) && ((mask_i & (mask_i - NREG'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/register_writeback.sv
// Write-back end of the 8x16 register file: single writes, LM bursts, bypassed reads, R7 redirect.
`default_nettype none
module register_writeback
  import rr_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  register_writeback_if.slave wb
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [0:0]        state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic              redir_valid_q;
  logic [DATA_W-1:0] redir_pc_q;

  logic              accept;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     enc_idx;
  logic [NREG-1:0]   enc_clr;
  logic              enc_last;

  lm_priority_enc u_enc (
    .mask_i (mask_q),
    .idx_o  (enc_idx),
    .clr_o  (enc_clr),
    .last_o (enc_last)
  );

  assign wb.wb_ready = 1'b1;
  assign accept      = wb.wb_valid && wb.wb_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    wr_en   = 1'b0;
    wr_idx  = wb.wb_rd;
    if (state_q == WB_IDLE) begin
      if (accept && wb.wb_lm) begin
        mask_d  = wb.wb_mask;
        state_d = (wb.wb_mask != '0) ? WB_BURST : WB_IDLE;
      end else begin
        wr_en = accept;
      end
    end else begin
      wr_idx = enc_idx;
      wr_en  = accept;
      if (accept) begin
        mask_d = mask_q & ~enc_clr;
        if (enc_last) state_d = WB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= REG_INIT[i];
    end else if (wr_en) begin
      regs_q[wr_idx] <= wb.wb_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= WB_IDLE;
      mask_q        <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      redir_valid_q <= wr_en && (wr_idx == REG_PC);
      if (wr_en && (wr_idx == REG_PC)) redir_pc_q <= wb.wb_data;
    end
  end

  // Same-cycle bypass; LM headers never assert wr_en so they cannot bypass.
  assign wb.rd_data_a = (wr_en && (wr_idx == wb.rd_addr_a)) ? wb.wb_data : regs_q[wb.rd_addr_a];
  assign wb.rd_data_b = (wr_en && (wr_idx == wb.rd_addr_b)) ? wb.wb_data : regs_q[wb.rd_addr_b];

  assign wb.redirect_valid = redir_valid_q;
  assign wb.redirect_pc    = redir_pc_q;
  assign wb.flush          = redir_valid_q;
  assign wb.busy           = (state_q == WB_BURST);

endmodule
`default_nettype wire

// File: tb/tb_register_writeback.sv
// Directed-vector bench for register_writeback.
`default_nettype none
module tb_register_writeback;
  import rr_pkg::*;

  logic clk;
  logic resetn;
  int   tests_run;
  int   tests_failed;

  logic [15:0] init_tbl [8];

  register_writeback_if bus ();

  register_writeback dut (
    .clk    (clk),
    .resetn (resetn),
    .wb     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic v, input logic lm, input logic [7:0] mask,
                      input logic [2:0] rd, input logic [15:0] data);
    @(negedge clk);
    bus.wb_valid = v;
    bus.wb_lm    = lm;
    bus.wb_mask  = mask;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_lm = 1'b0; bus.wb_mask = '0;
    bus.wb_rd = '0; bus.wb_data = '0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    #12;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      #1;
      tests_run++;
      if (bus.rd_data_a !== init_tbl[i]) begin
        tests_failed++;
        $display("FAIL reset_reg R%0d got %h expected %h", i, bus.rd_data_a, init_tbl[i]);
      end
    end
    tests_run++;
    if ({bus.wb_ready, bus.busy, bus.flush, bus.redirect_valid} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_ctrl ready/busy/flush/rv got %b expected 1000",
               {bus.wb_ready, bus.busy, bus.flush, bus.redirect_valid});
    end
    tests_run++;
    if (bus.redirect_pc !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_pc got %h expected 0000", bus.redirect_pc);
    end
  endtask

  task automatic test_single();
    bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd2;
    beat(1'b1, 1'b0, 8'h00, 3'd3, 16'hBEEF);
    tests_run++;
    if (bus.rd_data_a !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL single_bypass got %h expected BEEF", bus.rd_data_a);
    end
    tests_run++;
    if (bus.rd_data_b !== 16'h0003) begin
      tests_failed++;
      $display("FAIL single_other_r2 got %h expected 0003", bus.rd_data_b);
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    bus.rd_addr_b = 3'd4;
    #1;
    tests_run++;
    if (bus.rd_data_a !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL single_stored got %h expected BEEF", bus.rd_data_a);
    end
    tests_run++;
    if (bus.rd_data_b !== 16'h0005) begin
      tests_failed++;
      $display("FAIL single_other_r4 got %h expected 0005", bus.rd_data_b);
    end
  endtask

  task automatic test_lm_burst();
    logic [15:0] data [3];
    logic [2:0]  tgt  [3];
    data = '{16'h1111, 16'h2222, 16'h3333};
    tgt  = '{3'd1, 3'd2, 3'd5};
    bus.rd_addr_a = 3'd1;
    beat(1'b1, 1'b1, 8'h26, 3'd1, 16'h9999);
    tests_run++;
    if (bus.rd_data_a !== 16'h0002) begin
      tests_failed++;
      $display("FAIL lm_header_nobypass got %h expected 0002", bus.rd_data_a);
    end
    for (int k = 0; k < 3; k++) begin
      bus.rd_addr_a = tgt[k];
      beat(1'b1, 1'b0, 8'h00, 3'd0, data[k]);
      tests_run++;
      if (bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL lm_busy beat%0d got %b expected 1", k, bus.busy);
      end
      tests_run++;
      if (bus.rd_data_a !== data[k]) begin
        tests_failed++;
        $display("FAIL lm_bypass beat%0d got %h expected %h", k, bus.rd_data_a, data[k]);
      end
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lm_busy_end got %b expected 0", bus.busy);
    end
    for (int k = 0; k < 3; k++) begin
      bus.rd_addr_a = tgt[k];
      #1;
      tests_run++;
      if (bus.rd_data_a !== data[k]) begin
        tests_failed++;
        $display("FAIL lm_stored R%0d got %h expected %h", tgt[k], bus.rd_data_a, data[k]);
      end
    end
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd3;
    #1;
    tests_run++;
    if ({bus.rd_data_a, bus.rd_data_b} !== {16'h0001, 16'hBEEF}) begin
      tests_failed++;
      $display("FAIL lm_untouched R0/R3 got %h/%h expected 0001/BEEF", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  task automatic test_lm_r7();
    bus.rd_addr_b = 3'd7;
    beat(1'b1, 1'b1, 8'h81, 3'd0, 16'h0000);
    beat(1'b1, 1'b0, 8'h00, 3'd0, 16'hAAAA);
    beat(1'b1, 1'b0, 8'h00, 3'd0, 16'h0040);
    tests_run++;
    if ({bus.rd_data_b, bus.redirect_valid} !== {16'h0040, 1'b0}) begin
      tests_failed++;
      $display("FAIL r7_beat bypass/rv got %h/%b expected 0040/0", bus.rd_data_b, bus.redirect_valid);
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    tests_run++;
    if ({bus.redirect_valid, bus.flush, bus.redirect_pc, bus.busy} !== {1'b1, 1'b1, 16'h0040, 1'b0}) begin
      tests_failed++;
      $display("FAIL r7_pulse rv/flush/pc/busy got %b/%b/%h/%b expected 1/1/0040/0",
               bus.redirect_valid, bus.flush, bus.redirect_pc, bus.busy);
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    tests_run++;
    if ({bus.redirect_valid, bus.flush} !== 2'b00) begin
      tests_failed++;
      $display("FAIL r7_pulse_end rv/flush got %b%b expected 00", bus.redirect_valid, bus.flush);
    end
    bus.rd_addr_a = 3'd0;
    #1;
    tests_run++;
    if ({bus.rd_data_a, bus.rd_data_b} !== {16'hAAAA, 16'h0040}) begin
      tests_failed++;
      $display("FAIL r7_stored R0/R7 got %h/%h expected AAAA/0040", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  task automatic test_back_to_back();
    beat(1'b1, 1'b0, 8'h00, 3'd7, 16'h0100);
    beat(1'b1, 1'b0, 8'h00, 3'd7, 16'h0200);
    tests_run++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 16'h0100}) begin
      tests_failed++;
      $display("FAIL b2b_first rv/pc got %b/%h expected 1/0100", bus.redirect_valid, bus.redirect_pc);
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    tests_run++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 16'h0200}) begin
      tests_failed++;
      $display("FAIL b2b_second rv/pc got %b/%h expected 1/0200", bus.redirect_valid, bus.redirect_pc);
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    tests_run++;
    if (bus.redirect_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end rv got %b expected 0", bus.redirect_valid);
    end
  endtask

  task automatic test_mask_zero();
    beat(1'b1, 1'b1, 8'h00, 3'd6, 16'h1234);
    beat(1'b1, 1'b0, 8'h00, 3'd6, 16'h0006);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask0_busy got %b expected 0", bus.busy);
    end
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    bus.rd_addr_a = 3'd6; bus.rd_addr_b = 3'd0;
    #1;
    tests_run++;
    if ({bus.rd_data_a, bus.rd_data_b} !== {16'h0006, 16'hAAAA}) begin
      tests_failed++;
      $display("FAIL mask0_regs R6/R0 got %h/%h expected 0006/AAAA", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  task automatic test_reset_mid_burst();
    beat(1'b1, 1'b1, 8'h0F, 3'd0, 16'h0000);
    beat(1'b1, 1'b0, 8'h00, 3'd0, 16'h5001);
    beat(1'b1, 1'b0, 8'h00, 3'd0, 16'h5002);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_busy_before got %b expected 1", bus.busy);
    end
    @(negedge clk);
    bus.wb_valid = 1'b0;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_busy_async got %b expected 0", bus.busy);
    end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      #1;
      tests_run++;
      if (bus.rd_data_a !== init_tbl[i]) begin
        tests_failed++;
        $display("FAIL midrst_reg R%0d got %h expected %h", i, bus.rd_data_a, init_tbl[i]);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    beat(1'b1, 1'b0, 8'h00, 3'd4, 16'h7777);
    beat(1'b0, 1'b0, 8'h00, 3'd0, 16'h0000);
    bus.rd_addr_a = 3'd4; bus.rd_addr_b = 3'd2;
    #1;
    tests_run++;
    if ({bus.rd_data_a, bus.rd_data_b, bus.busy} !== {16'h7777, 16'h0003, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_next_idle R4/R2/busy got %h/%h/%b expected 7777/0003/0",
               bus.rd_data_a, bus.rd_data_b, bus.busy);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    init_tbl = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0};
    test_reset();
    test_single();
    test_lm_burst();
    test_lm_r7();
    test_back_to_back();
    test_mask_zero();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
